// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: datapath width, the canonical NOP and the
// fetch-to-decode entry layout.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// Register array of fetch entries: one synchronous write port and one
// asynchronous read port feeding the decode stage.
module fetch_buffer_mem
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, so a reset here would only cost area and routing.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer between fetch and decode: a small FIFO of
// {pc, pc_plus4, instr} entries with back-pressure and flush on redirect.
module fetch_buffer
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [WIDTH-1:0]       in_pc_plus4,
  input  logic [WIDTH-1:0]       in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_pc,
  output logic [WIDTH-1:0]       out_pc_plus4,
  output logic [WIDTH-1:0]       out_instr,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  fetch_entry_t  wr_entry, rd_entry;

  // Full check ignores a same-cycle pop so the PC enable never depends on decode.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{pc:       XLEN'(in_pc),
                      pc_plus4: XLEN'(in_pc_plus4),
                      instr:    XLEN'(in_instr)};

  fetch_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // An empty buffer presents a NOP so decode never sees stale storage.
  always_comb begin
    out_pc       = '0;
    out_pc_plus4 = '0;
    out_instr    = WIDTH'(NOP_INSTR);
    if (out_valid) begin
      out_pc       = WIDTH'(rd_entry.pc);
      out_pc_plus4 = WIDTH'(rd_entry.pc_plus4);
      out_instr    = WIDTH'(rd_entry.instr);
    end
  end

  assign count = count_q;

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between the PC/instruction-memory fetch stage and the decode stage of the pipelined RV32I core. It queues fetched {PC, PC+4, instruction} triples in a small FIFO, decoupling fetch from decode stalls. It back-pressures the PC register through `in_ready`, which drives the PC enable. It discards all queued instructions on a taken branch or jump (`flush`).

## Interface
Parameters:
- `WIDTH`, 32, datapath width for PC and instruction
- `DEPTH`, 4, number of entries; power of two, at least 2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch stage presents a valid entry
- `in_pc`  in  WIDTH  PC of the fetched instruction
- `in_pc_plus4`  in  WIDTH  PC+4 of the fetched instruction
- `in_instr`  in  WIDTH  fetched instruction word
- `in_ready`  out  1  buffer accepts an entry this cycle; drives the PC register enable
- `flush`  in  1  taken branch/jump resolved; discard all entries
- `out_valid`  out  1  head entry valid for decode
- `out_pc`  out  WIDTH  PC of the head entry
- `out_pc_plus4`  out  WIDTH  PC+4 of the head entry
- `out_instr`  out  WIDTH  head instruction; NOP when empty
- `out_ready`  in  1  decode consumes the head entry this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: storage array[DEPTH], `wr_ptr` and `rd_ptr` ($clog2(DEPTH) bits, wrap naturally), and `count`.
- Push = `in_valid && in_ready && !flush`. Pop = `out_valid && out_ready && !flush`.
- `in_ready` = (`count` != DEPTH). It ignores a same-cycle pop, so there is no push into a full buffer.
- `out_valid` = (`count` != 0).
- `out_pc`, `out_pc_plus4` and `out_instr` come combinationally from `array[rd_ptr]` when `out_valid` is 1.
- When empty, `out_instr` is 0x00000013 (addi x0,x0,0) and `out_pc` and `out_pc_plus4` are 0.
- Push writes to `array[wr_ptr]` and increments `wr_ptr`.
- Pop increments `rd_ptr`.
- `count` changes by +1 on push only, -1 on pop only, and 0 when both happen together.
- `flush` has priority over everything. Next cycle `count`, `wr_ptr` and `rd_ptr` are 0. A same-cycle `in_valid` entry is dropped and a same-cycle pop is not counted.
- Pop when empty cannot occur because `out_valid` is 0; `out_ready` is ignored when empty.
- Storage contents are not reset; only pointers and `count` are.

## Timing
- Reset (`rst` = 0, asynchronous, also mid-operation): immediately `count` = 0, `out_valid` = 0, `in_ready` = 1, `out_instr` = 0x00000013, `out_pc` = 0, `out_pc_plus4` = 0.
- Latency: an entry pushed at edge N is visible on `out_*` after edge N. There is no combinational fall-through from `in_*` to `out_*`.
- Throughput: one push and one pop per cycle in steady state. There is a one-cycle bubble only after flush, reset or empty.
- Full: `in_ready` drops the cycle after the DEPTH-th push and rises the cycle after the first pop.
- Pointer wrap-around at DEPTH is seamless; order is strictly FIFO.
- Flush with the buffer full: `in_ready` = 1 on the following cycle.

## Structure
- Shared package `rv_pkg` holds:
  - `NOP_INSTR` = 32'h00000013
  - `fetch_entry_t` packed struct {pc, pc_plus4, instr}, reused by decode
- Natural sub-module: `fetch_buffer_mem`, a DEPTH×`fetch_entry_t` register array with a write port and an asynchronous read port.
- Pointer/count control stays in `fetch_buffer`.

## Test plan
- Reset mid-operation: after 3 pushes, pulse `rst` = 0 between edges -> immediately `count` = 0, `out_valid` = 0, `out_instr` = 0x00000013, `in_ready` = 1.
- Fill: push PCs 0x0, 0x4, 0x8, 0xC with `out_ready` = 0 -> `count` = 4, `in_ready` = 0, `out_pc` = 0x0; a fifth `in_valid` is not accepted.
- Simultaneous push/pop at `count` = 2 (heads 0x0, 0x4; push 0x8) -> `count` stays 2, `out_pc` = 0x4 next cycle.
- Flush with `in_valid` = 1 (PC 0x10) at `count` = 3 -> next cycle `count` = 0 and 0x10 is absent. Push 0x40 -> `out_pc` = 0x40 one cycle later.
- Wrap-around: continuous push/pop of PCs 0x0..0x24 with `out_ready` = 1 -> decode sees the 10 PCs in order with no drops or duplicates.
- Empty: `out_ready` = 1 with `count` = 0 for 3 cycles -> `count` stays 0, `out_instr` = 0x00000013, no underflow.
